// File: rtl/apl_pkg.sv
// Shared types and constants for the OpenCAPI request responder:
// stream/address typedefs and the response FIFO entry layout.
package apl_pkg;

    localparam int NSTRMS      = 64;
    localparam int SID_W       = $clog2(NSTRMS);
    localparam int L2_NCL      = 256;
    localparam int L2_NCL_W    = $clog2(L2_NCL);
    localparam int ADDR_W      = 57;
    localparam int OUTST       = 16;
    localparam int RSP_LAT     = 32;
    localparam int AGE_W       = 8;
    localparam int CL_BYTES    = 128;
    localparam int RSP_LAT_MAX = 255;

    typedef logic [SID_W-1:0]    sid_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [L2_NCL_W-1:0] off_t;
    typedef logic [AGE_W-1:0]    age_t;

    typedef struct packed {
        sid_t  sid;
        addr_t addr;
        age_t  age;
    } rsp_entry_t;

endpackage

// File: rtl/rsp_age_fifo.sv
// Circular FIFO of response entries; every live entry ages down to zero
// (saturating) and the head is presented once its age reaches zero.
module rsp_age_fifo
    import apl_pkg::*;
#(
    parameter int unsigned depth = 16,
    parameter int          cnt_w = $clog2(depth) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rsp_entry_t       push_entry,
    input  logic             pop,
    output rsp_entry_t       head,
    output logic             head_ripe,
    output logic [cnt_w-1:0] count
);

    localparam int PTR_W = $clog2(depth);

    rsp_entry_t       mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rel;
    logic [depth-1:0] live;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        live = '0;
        rel  = '0;
        for (int i = 0; i < depth; i++) begin
            rel     = PTR_W'(i) - rd_ptr;
            live[i] = (cnt_w'(rel) < count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (live[i] && (mem[i].age != '0)) begin
                    mem[i].age <= mem[i].age - age_t'(1);
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign head_ripe = (count != '0) && (head.age == '0);

endmodule

// File: rtl/ocapi_req_responder.sv
// OpenCAPI request/response channel responder: per-stream base+offset address
// generation feeding a fixed-latency in-order response FIFO.
// Optional statistics ports are enabled by defining OCAPI_RSP_STATS_EN.
module ocapi_req_responder
    import apl_pkg::*;
#(
    parameter int unsigned outst   = OUTST,
    parameter int unsigned rsp_lat = RSP_LAT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_cfg_v,
    input  sid_t  i_cfg_sid,
    input  addr_t i_cfg_base,
    input  logic  i_req_v,
    output logic  i_req_r,
    input  sid_t  i_req_sid,
    output logic  o_rsp_v,
    input  logic  o_rsp_r,
    output sid_t  o_rsp_sid,
    output addr_t o_rsp_addr,
    output logic  o_idle
`ifdef OCAPI_RSP_STATS_EN
    ,
    output logic [31:0]              o_stat_req,
    output logic [31:0]              o_stat_rsp,
    output logic [$clog2(outst):0]   o_stat_max
`endif
);

    localparam int CNT_W = $clog2(outst) + 1;

    addr_t            base_q [NSTRMS];
    off_t             off_q  [NSTRMS];
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             pop;
    logic             same_sid;
    addr_t            req_base;
    off_t             req_off;
    addr_t            req_addr;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic             head_ripe;

    assign i_req_r = reset && (count < CNT_W'(outst));
    assign accept  = i_req_v && i_req_r;
    assign pop     = o_rsp_v && o_rsp_r;

    // A same-cycle config to the requesting stream takes effect for that request.
    assign same_sid   = i_cfg_v && (i_cfg_sid == i_req_sid);
    assign req_base   = same_sid ? i_cfg_base : base_q[i_req_sid];
    assign req_off    = same_sid ? '0 : off_q[i_req_sid];
    assign req_addr   = req_base + ADDR_W'(req_off);
    assign push_entry = '{sid: i_req_sid, addr: req_addr, age: AGE_W'(rsp_lat)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSTRMS; i++) begin
                base_q[i] <= '0;
                off_q[i]  <= '0;
            end
        end else begin
            if (i_cfg_v) begin
                base_q[i_cfg_sid] <= i_cfg_base;
                off_q[i_cfg_sid]  <= '0;
            end
            if (accept) begin
                off_q[i_req_sid] <= req_off + off_t'(1);
            end
        end
    end

    rsp_age_fifo #(
        .depth (outst),
        .cnt_w (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_ripe  (head_ripe),
        .count      (count)
    );

    assign o_rsp_v    = head_ripe;
    assign o_rsp_sid  = head_ripe ? head.sid  : '0;
    assign o_rsp_addr = head_ripe ? head.addr : '0;
    assign o_idle     = (count == '0);

`ifdef OCAPI_RSP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_stat_req <= '0;
            o_stat_rsp <= '0;
            o_stat_max <= '0;
        end else begin
            if (accept) o_stat_req <= o_stat_req + 32'd1;
            if (pop)    o_stat_rsp <= o_stat_rsp + 32'd1;
            if (count > o_stat_max) o_stat_max <= count;
        end
    end
`endif

endmodule

// File: tb/tb_ocapi_req_responder.sv
// Self-checking bench for ocapi_req_responder: scoreboard of expected
// {sid, addr} beats plus per-scenario directed checks.
module tb_ocapi_req_responder;
    import apl_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  i_cfg_v;
    sid_t  i_cfg_sid;
    addr_t i_cfg_base;
    logic  i_req_v;
    logic  i_req_r;
    sid_t  i_req_sid;
    logic  o_rsp_v;
    logic  o_rsp_r;
    sid_t  o_rsp_sid;
    addr_t o_rsp_addr;
    logic  o_idle;
`ifdef OCAPI_RSP_STATS_EN
    logic [31:0] o_stat_req;
    logic [31:0] o_stat_rsp;
    logic [4:0]  o_stat_max;
`endif

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    ocapi_req_responder dut (
        .clk        (clk),
        .reset      (reset),
        .i_cfg_v    (i_cfg_v),
        .i_cfg_sid  (i_cfg_sid),
        .i_cfg_base (i_cfg_base),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_req_sid  (i_req_sid),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_r    (o_rsp_r),
        .o_rsp_sid  (o_rsp_sid),
        .o_rsp_addr (o_rsp_addr),
        .o_idle     (o_idle)
`ifdef OCAPI_RSP_STATS_EN
        ,
        .o_stat_req (o_stat_req),
        .o_stat_rsp (o_stat_rsp),
        .o_stat_max (o_stat_max)
`endif
    );

    int checks = 0;
    int errors = 0;

    // scoreboard
    logic [SID_W+ADDR_W-1:0] exp_q[$];
    logic [SID_W+ADDR_W-1:0] exp_beat;
    addr_t base_m [NSTRMS];
    off_t  off_m  [NSTRMS];
    addr_t obs_q[$];
    addr_t model_addr;
    int    acc_cnt = 0;
    int    rsp_cnt = 0;
    int    acc_since_reset = 0;
    int    accept_edge = 0;
    logic  prev_hold = 1'b0;
    sid_t  prev_sid;
    addr_t prev_addr;

    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (o_rsp_v !== 1'b1 || o_rsp_sid !== prev_sid || o_rsp_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b sid=%0d addr=%h, want v=1 sid=%0d addr=%h",
                             o_rsp_v, o_rsp_sid, o_rsp_addr, prev_sid, prev_addr);
                end
            end
            if (o_rsp_v === 1'b1 && o_rsp_r === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got sid=%0d addr=%h, want no response",
                             o_rsp_sid, o_rsp_addr);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({o_rsp_sid, o_rsp_addr} !== exp_beat) begin
                        errors++;
                        $display("FAIL rsp_beat: got sid=%0d addr=%h, want sid=%0d addr=%h",
                                 o_rsp_sid, o_rsp_addr, exp_beat[SID_W+ADDR_W-1:ADDR_W],
                                 exp_beat[ADDR_W-1:0]);
                    end
                end
                rsp_cnt++;
                obs_q.push_back(o_rsp_addr);
            end
            prev_hold = o_rsp_v && !o_rsp_r;
            prev_sid  = o_rsp_sid;
            prev_addr = o_rsp_addr;
            if (i_cfg_v) begin
                base_m[i_cfg_sid] = i_cfg_base;
                off_m[i_cfg_sid]  = '0;
            end
            if (i_req_v && i_req_r) begin
                model_addr = base_m[i_req_sid] + ADDR_W'(off_m[i_req_sid]);
                exp_q.push_back({i_req_sid, model_addr});
                off_m[i_req_sid] = off_m[i_req_sid] + off_t'(1);
                acc_cnt++;
                acc_since_reset++;
                accept_edge = cyc + 1;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_since_reset = 0;
        for (int i = 0; i < NSTRMS; i++) begin
            base_m[i] = '0;
            off_m[i]  = '0;
        end
    endtask

    task automatic drive_cfg(input sid_t sid, input addr_t base);
        i_cfg_v    = 1'b1;
        i_cfg_sid  = sid;
        i_cfg_base = base;
        step();
        i_cfg_v    = 1'b0;
    endtask

    task automatic drive_req(input sid_t sid);
        i_req_v   = 1'b1;
        i_req_sid = sid;
        step();
        i_req_v   = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n;
        n = 0;
        while (o_idle !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (o_idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain_timeout: o_idle=%b after %0d cycles, want 1", tag, o_idle, bound);
        end
    endtask

    task automatic wait_rsp_v(input int bound, input string tag);
        int n;
        n = 0;
        while (o_rsp_v !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (o_rsp_v !== 1'b1) begin
            errors++;
            $display("FAIL %s_rsp_timeout: o_rsp_v=%b after %0d cycles, want 1", tag, o_rsp_v, bound);
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset      = 1'b0;
        i_cfg_v    = 1'b0;
        i_cfg_sid  = '0;
        i_cfg_base = '0;
        i_req_v    = 1'b0;
        i_req_sid  = '0;
        o_rsp_r    = 1'b0;
        clear_model();
        repeat (3) step();
        checks += 5;
        if (i_req_r !== 1'b0) begin errors++; $display("FAIL reset_req_r: got %b want 0", i_req_r); end
        if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL reset_rsp_v: got %b want 0", o_rsp_v); end
        if (o_rsp_sid !== '0) begin errors++; $display("FAIL reset_rsp_sid: got %0d want 0", o_rsp_sid); end
        if (o_rsp_addr !== '0) begin errors++; $display("FAIL reset_rsp_addr: got %h want 0", o_rsp_addr); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", o_idle); end
        reset = 1'b1;
        step();
        checks++;
        if (i_req_r !== 1'b1) begin errors++; $display("FAIL post_reset_req_r: got %b want 1", i_req_r); end
    endtask

    task automatic test_latency();
        int n;
        o_rsp_r = 1'b1;
        while (cyc < 8) step();
        drive_cfg(sid_t'(3), 57'h1000);
        drive_req(sid_t'(3));
        n = 0;
        while (o_rsp_v !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        checks += 3;
        if (cyc != accept_edge + RSP_LAT) begin
            errors++;
            $display("FAIL latency: got %0d edges, want %0d", cyc - accept_edge, RSP_LAT);
        end
        if (o_rsp_sid !== sid_t'(3)) begin errors++; $display("FAIL latency_sid: got %0d want 3", o_rsp_sid); end
        if (o_rsp_addr !== 57'h1000) begin errors++; $display("FAIL latency_addr: got %h want 1000", o_rsp_addr); end
        step();
        checks += 2;
        if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL latency_v_low: got %b want 0", o_rsp_v); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL latency_idle: got %b want 1", o_idle); end
    endtask

    task automatic test_offset_wrap();
        int start;
        int n;
        obs_q.delete();
        o_rsp_r = 1'b1;
        drive_cfg(sid_t'(5), 57'h200);
        start     = acc_cnt;
        i_req_v   = 1'b1;
        i_req_sid = sid_t'(5);
        n = 0;
        while ((acc_cnt - start) < 257 && n < 3000) begin
            step();
            n++;
        end
        i_req_v = 1'b0;
        checks++;
        if ((acc_cnt - start) != 257) begin
            errors++;
            $display("FAIL wrap_accepts: got %0d want 257", acc_cnt - start);
        end
        wait_idle(200, "wrap");
        checks++;
        if (obs_q.size() != 257) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 257", obs_q.size());
        end else begin
            checks += 3;
            if (obs_q[0] !== 57'h200) begin errors++; $display("FAIL wrap_first: got %h want 200", obs_q[0]); end
            if (obs_q[255] !== 57'h2ff) begin errors++; $display("FAIL wrap_last: got %h want 2ff", obs_q[255]); end
            if (obs_q[256] !== 57'h200) begin errors++; $display("FAIL wrap_again: got %h want 200", obs_q[256]); end
        end
    endtask

    task automatic test_full_backpressure();
        int start;
        o_rsp_r   = 1'b0;
        start     = acc_cnt;
        i_req_v   = 1'b1;
        i_req_sid = sid_t'(9);
        repeat (20) step();
        i_req_v = 1'b0;
        checks += 2;
        if ((acc_cnt - start) != OUTST) begin
            errors++;
            $display("FAIL full_accepts: got %0d want %0d", acc_cnt - start, OUTST);
        end
        if (i_req_r !== 1'b0) begin errors++; $display("FAIL full_req_r: got %b want 0", i_req_r); end
        wait_rsp_v(80, "full");
        repeat (20) step();
        o_rsp_r = 1'b1;
        @(negedge clk);
        checks++;
        if (i_req_r !== 1'b0) begin errors++; $display("FAIL full_req_r_prepop: got %b want 0", i_req_r); end
        for (int k = 0; k < OUTST; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (o_rsp_v !== 1'b1) begin
                errors++;
                $display("FAIL full_drain_beat%0d: got v=%b want 1", k, o_rsp_v);
            end
            if (k == 1) begin
                checks++;
                if (i_req_r !== 1'b1) begin errors++; $display("FAIL full_req_r_postpop: got %b want 1", i_req_r); end
            end
        end
        @(negedge clk);
        checks += 2;
        if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL full_empty_v: got %b want 0", o_rsp_v); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL full_empty_idle: got %b want 1", o_idle); end
        step();
    endtask

    task automatic test_back_to_back();
        int a0;
        int r0;
        a0 = acc_cnt;
        r0 = rsp_cnt;
        o_rsp_r = 1'b1;
        i_req_v = 1'b1;
        for (int k = 0; k < 150; k++) begin
            i_req_sid = sid_t'($urandom_range(0, NSTRMS - 1));
            step();
        end
        i_req_v = 1'b0;
        wait_idle(200, "b2b");
        checks += 3;
        if ((acc_cnt - a0) <= OUTST) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d accepts want more than %0d", acc_cnt - a0, OUTST);
        end
        if ((acc_cnt - a0) != (rsp_cnt - r0)) begin
            errors++;
            $display("FAIL b2b_balance: got %0d responses want %0d", rsp_cnt - r0, acc_cnt - a0);
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_cfg_collision();
        wait_idle(100, "coll_pre");
        obs_q.delete();
        o_rsp_r = 1'b0;
        drive_cfg(sid_t'(7), 57'h50);
        repeat (5) drive_req(sid_t'(7));
        i_cfg_v    = 1'b1;
        i_cfg_sid  = sid_t'(7);
        i_cfg_base = 57'h900;
        i_req_v    = 1'b1;
        i_req_sid  = sid_t'(7);
        step();
        i_cfg_v = 1'b0;
        i_req_v = 1'b0;
        drive_req(sid_t'(7));
        o_rsp_r = 1'b1;
        wait_idle(100, "coll");
        checks++;
        if (obs_q.size() != 7) begin
            errors++;
            $display("FAIL coll_count: got %0d want 7", obs_q.size());
        end else begin
            checks += 3;
            if (obs_q[4] !== 57'h54) begin errors++; $display("FAIL coll_queued: got %h want 54", obs_q[4]); end
            if (obs_q[5] !== 57'h900) begin errors++; $display("FAIL coll_same: got %h want 900", obs_q[5]); end
            if (obs_q[6] !== 57'h901) begin errors++; $display("FAIL coll_next: got %h want 901", obs_q[6]); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            i_cfg_v    = ($urandom_range(0, 7) == 0);
            i_cfg_sid  = sid_t'($urandom_range(0, 7));
            i_cfg_base = addr_t'({$urandom, $urandom});
            i_req_v    = ($urandom_range(0, 1) == 1);
            i_req_sid  = sid_t'($urandom_range(0, 7));
            o_rsp_r    = ($urandom_range(0, 9) < 7);
            step();
        end
        i_cfg_v = 1'b0;
        i_req_v = 1'b0;
        o_rsp_r = 1'b1;
        wait_idle(200, "rand");
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); end
`ifdef OCAPI_RSP_STATS_EN
        checks += 3;
        if (o_stat_req !== 32'(acc_since_reset)) begin
            errors++; $display("FAIL stat_req: got %0d want %0d", o_stat_req, acc_since_reset);
        end
        if (o_stat_rsp !== 32'(acc_since_reset)) begin
            errors++; $display("FAIL stat_rsp: got %0d want %0d", o_stat_rsp, acc_since_reset);
        end
        if (o_stat_max !== 5'd16) begin errors++; $display("FAIL stat_max: got %0d want 16", o_stat_max); end
`endif
    endtask

    task automatic test_reset_midflight();
        int start;
        int r0;
        wait_idle(100, "mid_pre");
        o_rsp_r = 1'b0;
        start   = acc_cnt;
        repeat (8) drive_req(sid_t'(2));
        checks++;
        if ((acc_cnt - start) != 8) begin errors++; $display("FAIL mid_accepts: got %0d want 8", acc_cnt - start); end
        #3;
        reset = 1'b0;
        #1;
        clear_model();
        checks += 3;
        if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL mid_rsp_v: got %b want 0", o_rsp_v); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", o_idle); end
        if (i_req_r !== 1'b0) begin errors++; $display("FAIL mid_req_r: got %b want 0", i_req_r); end
`ifdef OCAPI_RSP_STATS_EN
        checks += 3;
        if (o_stat_req !== 32'd0) begin errors++; $display("FAIL mid_stat_req: got %0d want 0", o_stat_req); end
        if (o_stat_rsp !== 32'd0) begin errors++; $display("FAIL mid_stat_rsp: got %0d want 0", o_stat_rsp); end
        if (o_stat_max !== 5'd0) begin errors++; $display("FAIL mid_stat_max: got %0d want 0", o_stat_max); end
`endif
        step();
        reset   = 1'b1;
        o_rsp_r = 1'b1;
        r0      = rsp_cnt;
        repeat (60) step();
        checks += 2;
        if (rsp_cnt != r0) begin errors++; $display("FAIL mid_stale: got %0d responses want 0", rsp_cnt - r0); end
        if (o_idle !== 1'b1) begin errors++; $display("FAIL mid_idle_after: got %b want 1", o_idle); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_offset_wrap();
        test_full_backpressure();
        test_back_to_back();
        test_cfg_collision();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
